// File: rtl/axi_read_arbiter_if.sv
// AXI read-channel bundle (AR + R) shared by the arbiter's master and slave sides.
//   master modport : drives AR payload/ARVALID and RREADY; receives ARREADY and R payload/RVALID
//   slave modport  : mirror image of master
// ID_WIDTH differs per instance: master-side ports use the narrow ID, the slave port the wide one.
interface axi_read_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned LEN_WIDTH  = 4
);
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [LEN_WIDTH-1:0]  ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter with a single outstanding transaction.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   m0  : master 0 read channel (arbiter is the slave)
//   m1  : master 1 read channel (arbiter is the slave)
//   s   : downstream slave read channel (arbiter is the master); ARID carries {grant, master ID}
// Optional macro ROUND_ROBIN_EN: alternate the winner on simultaneous requests;
// without it master 0 has fixed priority.
module axi_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned IDS_WIDTH  = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  pick;
  logic                  grant;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [LEN_WIDTH-1:0]  ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  in_data;
  logic                  rready_sel;
  logic                  unused_rid;

  // Winner among current requesters (only meaningful when accept is high)
`ifdef ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    if (m0.ARVALID && m1.ARVALID) pick = ~last_grant;
    else                          pick = m1.ARVALID;
  end

  // Pointer resets to M1 so the first contended grant goes to M0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= pick;
  end
`else
  assign pick = ~m0.ARVALID;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (m0.ARVALID || m1.ARVALID) begin
          accept    = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (s.ARREADY) state_nxt = DATA;
      end
      DATA: begin
        if (s.RVALID && rready_sel && s.RLAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured AR payload and grant, held stable through ADDR and DATA
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= 1'b0;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else if (accept) begin
      grant    <= pick;
      ar_id    <= pick ? m1.ARID    : m0.ARID;
      ar_addr  <= pick ? m1.ARADDR  : m0.ARADDR;
      ar_len   <= pick ? m1.ARLEN   : m0.ARLEN;
      ar_size  <= pick ? m1.ARSIZE  : m0.ARSIZE;
      ar_burst <= pick ? m1.ARBURST : m0.ARBURST;
    end
  end

  // Grant handshake is combinational; masked during reset since state alone cannot block it
  assign m0.ARREADY = ~rst & accept & ~pick;
  assign m1.ARREADY = ~rst & accept &  pick;

  assign s.ARVALID = (state == ADDR);
  assign s.ARID    = IDS_WIDTH'({grant, ar_id});
  assign s.ARADDR  = ar_addr;
  assign s.ARLEN   = ar_len;
  assign s.ARSIZE  = ar_size;
  assign s.ARBURST = ar_burst;

  // R routing follows the registered grant; RID_S upper bits are not consulted
  assign in_data    = (state == DATA);
  assign rready_sel = grant ? m1.RREADY : m0.RREADY;
  assign s.RREADY   = in_data & rready_sel;
  assign m0.RVALID  = in_data & ~grant & s.RVALID;
  assign m1.RVALID  = in_data &  grant & s.RVALID;

  assign m0.RID   = s.RID[ID_WIDTH-1:0];
  assign m0.RDATA = s.RDATA;
  assign m0.RRESP = s.RRESP;
  assign m0.RLAST = s.RLAST;
  assign m1.RID   = s.RID[ID_WIDTH-1:0];
  assign m1.RDATA = s.RDATA;
  assign m1.RRESP = s.RRESP;
  assign m1.RLAST = s.RLAST;

  assign unused_rid = ^s.RID[IDS_WIDTH-1:ID_WIDTH];

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios followed by random reads,
// checked against a transaction-level model of arbitration and routing.
module tb_axi_read_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   last_g;   // model's last-granted master (reset value M1)

  axi_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4)) m0_if ();
  axi_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4)) m1_if ();
  axi_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .LEN_WIDTH(4)) s_if ();

  axi_read_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .IDS_WIDTH(8), .LEN_WIDTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid_s"}, s_if.ARVALID, 1'b0);
    chk({tag, "_rready_s"},  s_if.RREADY,  1'b0);
    chk({tag, "_rvalid_m0"}, m0_if.RVALID, 1'b0);
    chk({tag, "_rvalid_m1"}, m1_if.RVALID, 1'b0);
  endtask

  // One complete read: request(s), address phase, data burst. Optional reset abort at beat rst_beat.
  task automatic txn(input bit r0, input bit r1, input int ar_wait, input logic [1:0] resp,
                     input logic [3:0] len, input bit stall, input bit fixed, input int rst_beat);
    logic [3:0]  id0, id1, idw;
    logic [31:0] a0, a1, aw, data;
    logic [2:0]  szw;
    logic        wb, valid, rready;
    int          w, b, cyc, stall_cnt;

    id0 = fixed ? 4'h3 : 4'($urandom);
    id1 = 4'($urandom);
    a0  = fixed ? 32'h0000_0100 : $urandom;
    a1  = $urandom;

    @(negedge clk);
    m0_if.ARVALID = r0; m0_if.ARID = id0; m0_if.ARADDR = a0; m0_if.ARLEN = len;
    m0_if.ARSIZE = 3'd2; m0_if.ARBURST = 2'b01;
    m1_if.ARVALID = r1; m1_if.ARID = id1; m1_if.ARADDR = a1; m1_if.ARLEN = len;
    m1_if.ARSIZE = 3'd1; m1_if.ARBURST = 2'b10;

    // Reference arbitration
    if (r0 && r1) begin
`ifdef ROUND_ROBIN_EN
      w = (last_g == 1) ? 0 : 1;
`else
      w = 0;
`endif
    end else begin
      w = r1 ? 1 : 0;
    end
    last_g = w;
    wb  = (w == 1);
    idw = wb ? id1 : id0;
    aw  = wb ? a1 : a0;
    szw = wb ? 3'd1 : 3'd2;

    #1;
    chk("grant_arready_m0", m0_if.ARREADY, !wb);
    chk("grant_arready_m1", m1_if.ARREADY, wb);

    @(posedge clk);
    @(negedge clk);
    if (wb) m1_if.ARVALID = 1'b0; else m0_if.ARVALID = 1'b0;

    // Address phase: payload must hold while ARREADY_S is low; loser keeps requesting
    for (int k = 0; k <= ar_wait; k++) begin
      s_if.ARREADY = (k == ar_wait);
      #1;
      chk("addr_arvalid_s", s_if.ARVALID, 1'b1);
      chk("addr_arid_s",    s_if.ARID,    {3'b000, wb, idw});
      chk("addr_araddr_s",  s_if.ARADDR,  aw);
      chk("addr_arlen_s",   s_if.ARLEN,   len);
      chk("addr_arsize_s",  s_if.ARSIZE,  szw);
      chk("addr_arready_m0", m0_if.ARREADY, 1'b0);
      chk("addr_arready_m1", m1_if.ARREADY, 1'b0);
      chk("addr_rvalid_m0", m0_if.RVALID, 1'b0);
      chk("addr_rvalid_m1", m1_if.RVALID, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    s_if.ARREADY  = 1'b0;
    m0_if.ARVALID = 1'b0;
    m1_if.ARVALID = 1'b0;

    // Data phase
    b = 0; cyc = 0; stall_cnt = 0;
    while (b <= int'(len) && cyc < 400) begin
      if (b == rst_beat) begin
        rst = 1'b1;
        m1_if.ARVALID = 1'b1;
        s_if.RVALID = 1'b1;
        m0_if.RREADY = 1'b1;
        m1_if.RREADY = 1'b1;
        #1;
        chk_quiet("rst_abort");
        chk("rst_abort_arready_m0", m0_if.ARREADY, 1'b0);
        chk("rst_abort_arready_m1", m1_if.ARREADY, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m1_if.ARVALID = 1'b0;
        s_if.RVALID = 1'b0;
        last_g = 1;
        return;
      end
      valid = stall ? 1'b1 : ($urandom_range(3) != 0);
      if (stall && b == 1 && stall_cnt < 3) begin
        rready = 1'b0;
        stall_cnt++;
      end else begin
        rready = stall ? 1'b1 : ($urandom_range(2) != 0);
      end
      data = (fixed && b == 0) ? 32'hDEAD_BEEF : $urandom;
      s_if.RVALID = valid;
      s_if.RDATA  = data;
      s_if.RRESP  = resp;
      s_if.RLAST  = (b == int'(len));
      s_if.RID    = {3'($urandom), ~wb, idw};
      if (wb) begin m1_if.RREADY = rready; m0_if.RREADY = 1'($urandom); end
      else    begin m0_if.RREADY = rready; m1_if.RREADY = 1'($urandom); end
      #1;
      chk("data_rready_s",  s_if.RREADY, rready);
      chk("data_arvalid_s", s_if.ARVALID, 1'b0);
      if (wb) begin
        chk("data_rvalid_m1", m1_if.RVALID, valid);
        chk("data_rvalid_m0_other", m0_if.RVALID, 1'b0);
        chk("data_rdata_m1", m1_if.RDATA, data);
        chk("data_rresp_m1", m1_if.RRESP, resp);
        chk("data_rlast_m1", m1_if.RLAST, (b == int'(len)));
        chk("data_rid_m1",   m1_if.RID,   idw);
      end else begin
        chk("data_rvalid_m0", m0_if.RVALID, valid);
        chk("data_rvalid_m1_other", m1_if.RVALID, 1'b0);
        chk("data_rdata_m0", m0_if.RDATA, data);
        chk("data_rresp_m0", m0_if.RRESP, resp);
        chk("data_rlast_m0", m0_if.RLAST, (b == int'(len)));
        chk("data_rid_m0",   m0_if.RID,   idw);
      end
      @(posedge clk);
      if (valid && rready) b++;
      cyc++;
      @(negedge clk);
    end
    chk("beats_delivered", b, int'(len) + 1);
    s_if.RVALID  = 1'b0;
    s_if.RLAST   = 1'b0;
    m0_if.RREADY = 1'b0;
    m1_if.RREADY = 1'b0;
    #1;
    chk_quiet("after_last");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_g = 1;
    rst = 1'b1;
    m0_if.ARVALID = 1'b0; m0_if.ARID = '0; m0_if.ARADDR = '0; m0_if.ARLEN = '0;
    m0_if.ARSIZE = '0; m0_if.ARBURST = '0; m0_if.RREADY = 1'b0;
    m1_if.ARVALID = 1'b0; m1_if.ARID = '0; m1_if.ARADDR = '0; m1_if.ARLEN = '0;
    m1_if.ARSIZE = '0; m1_if.ARBURST = '0; m1_if.RREADY = 1'b0;
    s_if.ARREADY = 1'b0; s_if.RID = '0; s_if.RDATA = '0; s_if.RRESP = '0;
    s_if.RLAST = 1'b0; s_if.RVALID = 1'b0;

    // Reset state, with requests present to show the grant is blocked
    repeat (3) @(negedge clk);
    m0_if.ARVALID = 1'b1;
    m1_if.ARVALID = 1'b1;
    #1;
    chk_quiet("reset");
    chk("reset_arready_m0", m0_if.ARREADY, 1'b0);
    chk("reset_arready_m1", m1_if.ARREADY, 1'b0);
    chk("reset_araddr_s",   s_if.ARADDR,   32'h0);
    chk("reset_arid_s",     s_if.ARID,     8'h0);
    m0_if.ARVALID = 1'b0;
    m1_if.ARVALID = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single M0 read with known ID/address/data, slave ready after 2 cycles
    txn(1'b1, 1'b0, 2, 2'b00, 4'd0, 1'b0, 1'b1, -1);
    // Three contended rounds, then M1 alone
    repeat (3) txn(1'b1, 1'b1, 0, 2'b00, 4'd1, 1'b0, 1'b0, -1);
    txn(1'b0, 1'b1, 0, 2'b00, 4'd0, 1'b0, 1'b0, -1);
    // M1 4-beat burst with master backpressure on beat 2
    txn(1'b0, 1'b1, 0, 2'b00, 4'd3, 1'b1, 1'b0, -1);
    // Slave withholds ARREADY for 10 cycles
    txn(1'b1, 1'b1, 10, 2'b00, 4'd1, 1'b0, 1'b0, -1);
    // SLVERR passes through to M1
    txn(1'b0, 1'b1, 1, 2'b10, 4'd0, 1'b0, 1'b0, -1);
    // Reset during beat 2 of 4, then normal M1 service and pointer restart
    txn(1'b0, 1'b1, 0, 2'b00, 4'd3, 1'b1, 1'b0, 1);
    txn(1'b0, 1'b1, 0, 2'b00, 4'd1, 1'b0, 1'b0, -1);
    txn(1'b1, 1'b1, 0, 2'b00, 4'd0, 1'b0, 1'b0, -1);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = int'($urandom_range(2));
      txn(sel != 1, sel != 0, int'($urandom_range(3)), 2'($urandom),
          4'($urandom_range(7)), 1'b0, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 The block SHALL have parameter ID_WIDTH, default 4, master-side ID width.
REQ-004 The block SHALL have parameter IDS_WIDTH, default 8, slave-side ID width; IDS_WIDTH SHALL be at least ID_WIDTH+1.
REQ-005 The block SHALL have parameter LEN_WIDTH, default 4, burst length width.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 ARID_Mx, x=0,1  input  ID_WIDTH  master read address ID.
REQ-009 ARADDR_Mx / ARLEN_Mx / ARSIZE_Mx / ARBURST_Mx  input  ADDR_WIDTH / LEN_WIDTH / 3 / 2  master AR payload.
REQ-010 ARVALID_Mx  input  1 / ARREADY_Mx  output  1  master AR handshake.
REQ-011 RID_Mx  output  ID_WIDTH / RDATA_Mx  output  DATA_WIDTH / RRESP_Mx  output  2 / RLAST_Mx  output  1  master R payload.
REQ-012 RVALID_Mx  output  1 / RREADY_Mx  input  1  master R handshake.
REQ-013 ARID_S  output  IDS_WIDTH / ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  output  as master  slave AR payload.
REQ-014 ARVALID_S  output  1 / ARREADY_S  input  1  slave AR handshake.
REQ-015 RID_S  input  IDS_WIDTH / RDATA_S, RRESP_S, RLAST_S  input  as master  slave R payload.
REQ-016 RVALID_S  input  1 / RREADY_S  output  1  slave R handshake.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, DATA; at most one read transaction SHALL be outstanding.
REQ-018 IDLE: if any ARVALID_Mx=1, the block SHALL grant one master, assert ARREADY_Mg=1 combinationally in that cycle, register its AR payload and move to ADDR; otherwise it stays in IDLE.
REQ-019 ARREADY_Mx SHALL be 0 in ADDR and DATA and for the non-granted master.
REQ-020 ADDR: ARVALID_S=1 with registered payload; ARID_S={zeros, g, ARID_Mg} (bit ID_WIDTH = granted index); the payload SHALL remain stable until ARREADY_S=1; then move to DATA.
REQ-021 DATA: RVALID_Mg=RVALID_S, RREADY_S=RREADY_Mg, RDATA/RRESP/RLAST forwarded combinationally, RID_Mg=RID_S[ID_WIDTH-1:0]; the other master's RVALID SHALL be 0.
REQ-022 DATA SHALL exit to IDLE on the cycle RVALID_S & RREADY_S & RLAST_S=1; beats without RLAST SHALL keep DATA (bursts up to 2^LEN_WIDTH beats).
REQ-023 Routing SHALL follow the registered grant, not RID_S; RRESP_S SHALL pass through unmodified.
REQ-024 Outside DATA, RREADY_S SHALL be 0 and all RVALID_Mx SHALL be 0.
REQ-025 Latency: ARVALID_Mx accepted in cycle n gives ARVALID_S=1 in cycle n+1; the earliest new grant is the cycle after the last R beat.
REQ-026 A master whose ARVALID drops before grant SHALL NOT be granted; the block SHALL NOT check AXI legality.

Reset
REQ-027 While rst=1: state IDLE; ARREADY_Mx, ARVALID_S, RVALID_Mx, RREADY_S = 0; registered payload = 0; last-grant pointer = M1.
REQ-028 rst asserted mid-ADDR or mid-DATA SHALL abort immediately without completing the handshake; the first grant after release follows REQ-027.

Configuration
REQ-029 Macro ROUND_ROBIN_EN defined: on a simultaneous request, the master not granted last SHALL win; the pointer SHALL update at each grant.
REQ-030 Macro ROUND_ROBIN_EN undefined: M0 SHALL always win a simultaneous request; the pointer logic SHALL be absent.

Verification
REQ-031 Only M0 requests, ARADDR_M0=0x0000_0100, ARID_M0=0x3; slave ARREADY_S after 2 cycles, one beat RDATA=0xDEADBEEF, RLAST=1 -> ARID_S=0x03, RID_M0=0x3, RDATA_M0=0xDEADBEEF, M1 sees no RVALID.
REQ-032 M0 and M1 request on the same cycle, with ROUND_ROBIN_EN, three back-to-back rounds -> grants M0, M1, M0; without the macro -> M0, M0, M0, with M1 served only when M0 is idle.
REQ-033 M1 4-beat burst, ARLEN_M1=3, RREADY_M1 deasserted on beat 2 for 3 cycles -> RREADY_S low those cycles, all 4 beats delivered in order, IDLE only after RLAST.
REQ-034 ARREADY_S held 0 for 10 cycles -> ARVALID_S and payload stable all 10 cycles, ARREADY_Mx stays 0.
REQ-035 rst pulsed during DATA beat 2 of 4 -> all handshake outputs 0 within the reset cycle; after release, a new M1 request is granted normally.
REQ-036 RRESP_S=2'b10 (SLVERR) on M1 read -> RRESP_M1=2'b10, FSM returns to IDLE.
